crc_clk1_tx_ctrl: RTL and testbench
===================================

// Module: crc_clk1_tx_ctrl
// PURPOSE
//  - clk_1-domain job scheduler for the CRC datapath. Queues captured input jobs {message, mode, CRC} in a small FIFO.
//  - Issues them one at a time to the clk_2 domain over a 4-phase req/ack handshake.
//  - Holds the transfer payload stable for the whole handshake; gives upstream backpressure and overflow status.
// PARAMETERS
//  MSG_W        60  message payload width
//  DEPTH         4  job FIFO entries (power of 2, >=2)
//  SYNC_STAGES   2  flops in the ack synchronizer (>=2)
// PORTS
//  clk_1        in   1      source clock
//  rst_n        in   1      async reset, active-low
//  in_valid     in   1      job present this cycle
//  message      in   MSG_W  job payload
//  mode         in   1      job mode bit, opaque, passed through
//  CRC          in   1      CRC-select bit, opaque, passed through
//  in_ready     out  1      FIFO not full (registered)
//  tx_req       out  1      4-phase request to clk_2 (registered)
//  tx_message   out  MSG_W  payload, stable while tx_req=1 or ack_sync=1
//  tx_mode      out  1      payload mode
//  tx_crc       out  1      payload CRC-select
//  rx_ack       in   1      ack from clk_2 domain (asynchronous)
//  job_done     out  1      1-cycle pulse when a handshake completes
//  pending      out  $clog2(DEPTH)+2  FIFO count + in-flight job
//  ovf_err      out  1      sticky: in_valid arrived while full
// BEHAVIOUR
//  - Reset (async): FIFO empty, state IDLE.
//    - All outputs 0: in_ready=0 during reset, 1 on the first clk_1 edge after release.
//    - tx_* payload registers reset to 0.
//  - Push: on in_valid && in_ready, write {message,mode,CRC}.
//    - in_ready = (count != DEPTH), from registered count only; no same-cycle bypass.
//    - in_valid while full: job dropped, ovf_err<=1 until reset, even if a pop occurs that same cycle.
//  - ack_sync = rx_ack through SYNC_STAGES flops. Only ack_sync is used.
//  - FSM, 3 states:
//    - IDLE: if FIFO !empty and ack_sync==0, then on the edge: pop head into tx_*, tx_req<=1, go REQ.
//    - REQ: tx_req=1, wait for ack_sync==1, then tx_req<=0, go REL.
//    - REL: wait for ack_sync==0, then job_done<=1 for one cycle, go IDLE.
//  - tx_message/tx_mode/tx_crc change only on the IDLE pop edge. They never change in REQ/REL.
//  - Latency from an empty, IDLE block:
//    - in_valid sampled at edge N, count=1 after N, tx_req=1 after edge N+1.
//    - Back-to-back jobs: next tx_req 1 cycle after job_done (IDLE pop edge).
//  - Simultaneous push and pop: count unchanged; push writes tail, pop reads head. Correct at count=1.
//  - Pointers wrap mod DEPTH. count is DEPTH+1 wide-safe ($clog2(DEPTH)+1 bits).
//  - pending = count + (state!=IDLE). Range 0..DEPTH+1.
//  - Spurious ack_sync=1 in IDLE (clk_2 lagging reset): no pop until ack_sync==0.
//  - Reset mid-handshake: tx_req drops immediately and the job is lost. The clk_2 side shares rst_n.
// STRUCTURE
//  - crc_pkg: MSG_W, job struct/width (MSG_W+2) and its field packing, FSM state encoding {IDLE,REQ,REL}.
//  - Sub-module crc_sync_bit (SYNC_STAGES-flop synchronizer, async reset to 0), reused by the clk_2 side for req.
//  - FIFO is inline: register array, wr/rd pointers, count. No memory macro.
// TESTING
//  - Single job, message=60'h0123_4567_89AB_CDE, mode=1, CRC=0, ack model delays 3 cycles:
//    tx_req rises 2 edges after in_valid with stable payload; job_done pulses once; pending returns 0.
//  - Burst of 5 in_valid with ack held low (DEPTH=4): 1 job in flight, 4 queued.
//    in_ready=0 for the 5th and no drop since in_ready was honoured by the stimulus.
//    Force a 6th in_valid while full: ovf_err=1 and stays 1; pending=5.
//  - Push and pop on the same edge at count=1: count stays 1. Issue order = input order.
//    Jobs 0xA, 0xB, 0xC come out as A, B, C.
//  - Randomised clk_2 ack delay 0..20 cycles, 1000 jobs: all payloads match in order;
//    tx_* never change while tx_req|ack_sync; no job lost.
//  - rx_ack=1 at reset release: no tx_req until rx_ack falls; then normal issue.
//  - Assert rst_n in REQ with 3 pending: all outputs 0 asynchronously; after release the block is idle and empty.

Source files
------------

// File: rtl/crc_clk1_tx_ctrl_pkg.sv
// Shared types for the clk_1 CRC job scheduler: job payload layout and FSM encoding.
package crc_clk1_tx_ctrl_pkg;

  localparam int MSG_W = 60;

  // Field order fixes the bit packing of a queued job: {message, mode, crc}.
  typedef struct packed {
    logic [MSG_W-1:0] message;
    logic             mode;
    logic             crc;
  } job_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    REL  = 2'd2
  } state_t;

  function automatic job_t pack_job(input logic [MSG_W-1:0] message,
                                    input logic mode,
                                    input logic crc);
    job_t j;
    j.message = message;
    j.mode    = mode;
    j.crc     = crc;
    return j;
  endfunction

endpackage

// File: rtl/crc_clk1_tx_ctrl_if.sv
// Upstream job port, clk_2 request/ack pair and status of the clk_1 CRC scheduler.
interface crc_clk1_tx_ctrl_if import crc_clk1_tx_ctrl_pkg::*; #(
  parameter int DEPTH = 4
) ();

  // in_valid/in_ready: a job moves on a clk_1 edge where both are 1; in_valid may be raised
  // without waiting for in_ready. tx_req/rx_ack: 4-phase, payload held from req rise to ack fall.
  logic                      in_valid;
  logic [MSG_W-1:0]          message;
  logic                      mode;
  logic                      CRC;
  logic                      in_ready;
  logic                      tx_req;
  logic [MSG_W-1:0]          tx_message;
  logic                      tx_mode;
  logic                      tx_crc;
  logic                      rx_ack;
  logic                      job_done;
  logic [$clog2(DEPTH)+1:0]  pending;
  logic                      ovf_err;
  state_t                    dbg_state;

  modport master (
    output in_valid, message, mode, CRC, rx_ack,
    input  in_ready, tx_req, tx_message, tx_mode, tx_crc, job_done, pending, ovf_err, dbg_state
  );

  modport slave (
    input  in_valid, message, mode, CRC, rx_ack,
    output in_ready, tx_req, tx_message, tx_mode, tx_crc, job_done, pending, ovf_err, dbg_state
  );

endinterface

// File: rtl/crc_clk1_tx_ctrl_sync.sv
// Multi-flop single-bit synchronizer with asynchronous active-low reset to 0.
module crc_sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ff <= '0;
    else        ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/crc_clk1_tx_ctrl.sv
// clk_1 job scheduler: queues CRC jobs in a small FIFO and issues them one at a time
// to the clk_2 domain over a 4-phase req/ack handshake.
module crc_clk1_tx_ctrl import crc_clk1_tx_ctrl_pkg::*; #(
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk_1,
  input  logic               rst_n,
  crc_clk1_tx_ctrl_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  job_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_nxt;
  logic          in_ready_q, ovf_q;
  logic          ack_sync, push, pop;
  logic          tx_req_q, tx_req_nxt, job_done_q, job_done_nxt;
  job_t          tx_job;
  state_t        state, state_nxt;

  crc_sync_bit #(.STAGES(SYNC_STAGES)) u_ack_sync (
    .clk   (clk_1),
    .rst_n (rst_n),
    .d     (bus.rx_ack),
    .q     (ack_sync)
  );

  // A lingering ack from the previous handshake (or a lagging clk_2 reset) blocks issue.
  assign push      = bus.in_valid && in_ready_q;
  assign pop       = (state == IDLE) && (count != '0) && !ack_sync;
  assign count_nxt = count + CW'(push) - CW'(pop);

  always_ff @(posedge clk_1) begin
    if (push) mem[wr_ptr] <= pack_job(bus.message, bus.mode, bus.CRC);
  end

  always_ff @(posedge clk_1 or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      in_ready_q <= 1'b0;
      ovf_q      <= 1'b0;
      tx_job     <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
        tx_job <= mem[rd_ptr];
      end
      count      <= count_nxt;
      in_ready_q <= (count_nxt != CW'(DEPTH));
      if (bus.in_valid && !in_ready_q) ovf_q <= 1'b1;
    end
  end

  always_ff @(posedge clk_1 or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      tx_req_q   <= 1'b0;
      job_done_q <= 1'b0;
    end else begin
      state      <= state_nxt;
      tx_req_q   <= tx_req_nxt;
      job_done_q <= job_done_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    tx_req_nxt   = 1'b0;
    job_done_nxt = 1'b0;
    unique case (state)
      IDLE: begin
        if (pop) begin
          state_nxt  = REQ;
          tx_req_nxt = 1'b1;
        end
      end
      REQ: begin
        tx_req_nxt = 1'b1;
        if (ack_sync) begin
          tx_req_nxt = 1'b0;
          state_nxt  = REL;
        end
      end
      REL: begin
        if (!ack_sync) begin
          job_done_nxt = 1'b1;
          state_nxt    = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.ovf_err    = ovf_q;
  assign bus.tx_req     = tx_req_q;
  assign bus.job_done   = job_done_q;
  assign bus.tx_message = tx_job.message;
  assign bus.tx_mode    = tx_job.mode;
  assign bus.tx_crc     = tx_job.crc;
  assign bus.pending    = {1'b0, count} + (CW+1)'(state != IDLE);
  assign bus.dbg_state  = state;

endmodule

// File: tb/tb_crc_clk1_tx_ctrl.sv
// Directed and randomised-ack bench for crc_clk1_tx_ctrl with a payload-order scoreboard.
module tb_crc_clk1_tx_ctrl;
  import crc_clk1_tx_ctrl_pkg::*;

  localparam int DEPTH = 4;
  localparam int PW    = MSG_W + 2;

  logic clk_1 = 1'b0;
  logic rst_n = 1'b0;

  crc_clk1_tx_ctrl_if #(.DEPTH(DEPTH)) bus ();

  crc_clk1_tx_ctrl #(.DEPTH(DEPTH), .SYNC_STAGES(2)) dut (
    .clk_1 (clk_1),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // clock / reset
  always #5 clk_1 = ~clk_1;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [PW-1:0] exp_q[$];
  int done_cnt = 0;
  int issued   = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // clk_2 side ack model: follows tx_req after a programmable number of cycles
  logic ack_auto   = 1'b1;
  logic ack_manual = 1'b0;
  logic ack_model;
  int   ack_cnt;
  int   ack_dly  = 3;
  int   dmin     = 3;
  int   dmax     = 3;

  always @(posedge clk_1 or negedge rst_n) begin
    if (!rst_n) begin
      ack_model <= 1'b0;
      ack_cnt   <= 0;
    end else if (bus.tx_req != ack_model) begin
      if (ack_cnt >= ack_dly) begin
        ack_model <= bus.tx_req;
        ack_cnt   <= 0;
        ack_dly   <= $urandom_range(dmax, dmin);
      end else begin
        ack_cnt <= ack_cnt + 1;
      end
    end else begin
      ack_cnt <= 0;
    end
  end

  assign bus.rx_ack = ack_auto ? ack_model : ack_manual;

  // monitor: pops the scoreboard on each new request and watches payload stability
  logic          req_prev = 1'b0;
  logic [PW-1:0] cur_job  = '0;

  always @(negedge clk_1) begin
    if (!rst_n) begin
      req_prev = 1'b0;
    end else begin
      if (bus.tx_req && !req_prev) begin
        issued++;
        cur_job = {bus.tx_message, bus.tx_mode, bus.tx_crc};
        if (exp_q.size() == 0) begin
          check("issue_unexpected", 64'(cur_job), 64'(1'b0) - 64'd1);
        end else begin
          check("issue_payload", 64'(cur_job), 64'(exp_q.pop_front()));
        end
      end else if (bus.dbg_state != IDLE) begin
        check("payload_stable", 64'({bus.tx_message, bus.tx_mode, bus.tx_crc}), 64'(cur_job));
      end
      if (bus.job_done) done_cnt++;
      req_prev = bus.tx_req;
    end
  end

  // driver tasks
  task automatic push_job(input logic [MSG_W-1:0] m, input logic md, input logic c,
                          input bit force_it);
    int  n = 0;
    bit  acc;
    while (!bus.in_ready && !force_it && n < 1000) begin
      @(posedge clk_1); #1;
      n++;
    end
    if (n >= 1000) check("in_ready_timeout", 64'(bus.in_ready), 64'd1);
    bus.in_valid = 1'b1;
    bus.message  = m;
    bus.mode     = md;
    bus.CRC      = c;
    acc          = bus.in_ready;
    @(posedge clk_1); #1;
    bus.in_valid = 1'b0;
    if (acc) exp_q.push_back({m, md, c});
  endtask

  task automatic wait_drain(input int max_cyc, input string nm);
    int n = 0;
    while ((bus.pending != 0) && n < max_cyc) begin
      @(posedge clk_1); #1;
      n++;
    end
    check(nm, 64'(bus.pending), 64'd0);
  endtask

  task automatic do_reset();
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk_1);
    #1;
    check("rst_in_ready", 64'(bus.in_ready), 64'd0);
    check("rst_tx_req",   64'(bus.tx_req),   64'd0);
    check("rst_pending",  64'(bus.pending),  64'd0);
    check("rst_ovf",      64'(bus.ovf_err),  64'd0);
    check("rst_tx_msg",   64'(bus.tx_message), 64'd0);
    exp_q.delete();
    rst_n = 1'b1;
    @(posedge clk_1); #1;
    check("rel_in_ready", 64'(bus.in_ready), 64'd1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    logic [63:0] r;
    bus.in_valid = 1'b0;
    bus.message  = '0;
    bus.mode     = 1'b0;
    bus.CRC      = 1'b0;
    do_reset();

    // single job, fixed 3-cycle ack
    push_job(60'h0123_4567_89AB_CDE, 1'b1, 1'b0, 1'b0);
    check("t1_pending_q", 64'(bus.pending), 64'd1);
    check("t1_req_early", 64'(bus.tx_req), 64'd0);
    @(posedge clk_1); #1;
    check("t1_req_rise", 64'(bus.tx_req), 64'd1);
    check("t1_msg", 64'(bus.tx_message), 64'h0123_4567_89AB_CDE);
    check("t1_mode", 64'(bus.tx_mode), 64'd1);
    check("t1_crc", 64'(bus.tx_crc), 64'd0);
    check("t1_pending_f", 64'(bus.pending), 64'd1);
    d0 = done_cnt;
    wait_drain(200, "t1_drain");
    repeat (3) @(posedge clk_1);
    #1;
    check("t1_done_once", 64'(done_cnt - d0), 64'd1);

    // burst of 5 with ack held low, then a forced 6th
    ack_auto = 1'b0;
    ack_manual = 1'b0;
    for (int i = 0; i < 5; i++) push_job(60'h100 + 60'(i), i[0], i[1], 1'b0);
    check("t2_in_ready", 64'(bus.in_ready), 64'd0);
    check("t2_pending5", 64'(bus.pending), 64'd5);
    check("t2_no_ovf", 64'(bus.ovf_err), 64'd0);
    push_job(60'hBAD, 1'b1, 1'b1, 1'b1);
    check("t2_ovf_set", 64'(bus.ovf_err), 64'd1);
    check("t2_pending_f", 64'(bus.pending), 64'd5);
    ack_auto = 1'b1;
    wait_drain(500, "t2_drain");
    check("t2_ovf_sticky", 64'(bus.ovf_err), 64'd1);

    // push and pop on the same edge at count=1, order A,B,C
    do_reset();
    push_job(60'hA, 1'b0, 1'b1, 1'b0);
    push_job(60'hB, 1'b1, 1'b0, 1'b0);
    check("t3_pending2", 64'(bus.pending), 64'd2);
    push_job(60'hC, 1'b1, 1'b1, 1'b0);
    wait_drain(500, "t3_drain");

    // randomised ack delay, 1000 jobs
    dmin = 0;
    dmax = 20;
    for (int i = 0; i < 1000; i++) begin
      r = {$urandom(), $urandom()};
      push_job(r[MSG_W-1:0], r[62], r[63], 1'b0);
      repeat ($urandom_range(2, 0)) @(posedge clk_1);
      #0;
    end
    wait_drain(2000, "t4_drain");
    repeat (3) @(posedge clk_1);
    #1;
    check("t4_sb_empty", 64'(exp_q.size()), 64'd0);

    // ack high at reset release blocks issue until it falls
    ack_auto = 1'b0;
    ack_manual = 1'b1;
    do_reset();
    push_job(60'h5A5, 1'b0, 1'b0, 1'b0);
    repeat (10) @(posedge clk_1);
    #1;
    check("t5_no_req", 64'(bus.tx_req), 64'd0);
    check("t5_pending", 64'(bus.pending), 64'd1);
    d0 = done_cnt;
    ack_manual = 1'b0;
    ack_auto = 1'b1;
    wait_drain(200, "t5_drain");
    repeat (3) @(posedge clk_1);
    #1;
    check("t5_done", 64'(done_cnt - d0), 64'd1);

    // reset asserted in REQ with 3 pending
    ack_auto = 1'b0;
    for (int i = 0; i < 3; i++) push_job(60'h300 + 60'(i), 1'b1, 1'b1, 1'b0);
    repeat (2) @(posedge clk_1);
    #1;
    check("t6_pending3", 64'(bus.pending), 64'd3);
    check("t6_state_req", 64'(bus.dbg_state), 64'(REQ));
    #3;
    rst_n = 1'b0;
    #1;
    check("t6_req0", 64'(bus.tx_req), 64'd0);
    check("t6_pend0", 64'(bus.pending), 64'd0);
    check("t6_rdy0", 64'(bus.in_ready), 64'd0);
    check("t6_msg0", 64'(bus.tx_message), 64'd0);
    check("t6_mode0", 64'({bus.tx_mode, bus.tx_crc, bus.job_done, bus.ovf_err}), 64'd0);
    exp_q.delete();
    repeat (2) @(posedge clk_1);
    #1;
    rst_n = 1'b1;
    ack_auto = 1'b1;
    repeat (2) @(posedge clk_1);
    #1;
    check("t6_idle", 64'(bus.dbg_state), 64'(IDLE));
    check("t6_empty", 64'(bus.pending), 64'd0);
    check("t6_ready", 64'(bus.in_ready), 64'd1);
    push_job(60'h777, 1'b0, 1'b1, 1'b0);
    wait_drain(200, "t6_drain");
    repeat (3) @(posedge clk_1);
    #1;
    check("final_sb_empty", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
